// File: rtl/lanes_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lanes_deserializer_pkg
// Description : Shared speed encodings, word lengths and state type for the
//               two-lane serial-to-parallel receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package lanes_deserializer_pkg;

    localparam logic [1:0] GEN4 = 2'b00;
    localparam logic [1:0] GEN3 = 2'b01;
    localparam logic [1:0] GEN2 = 2'b10;

    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] LEN_GEN4 = 8'd8;
    localparam logic [CNT_W-1:0] LEN_GEN3 = 8'd132;
    localparam logic [CNT_W-1:0] LEN_GEN2 = 8'd66;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The reserved code 2'b11 falls back to the GEN4 length.
    function automatic logic [CNT_W-1:0] word_len(input logic [1:0] gen);
        logic [CNT_W-1:0] len;
        case (gen)
            GEN3:    len = LEN_GEN3;
            GEN2:    len = LEN_GEN2;
            default: len = LEN_GEN4;
        endcase
        return len;
    endfunction

endpackage : lanes_deserializer_pkg
`default_nettype wire

// File: rtl/lanes_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : lanes_deserializer_if
// Description : Serial inputs, control and parallel outputs of the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface lanes_deserializer_if #(
    parameter int WIDTH = 132
);
    logic             enable_deser;
    logic [1:0]       gen_speed;
    logic             lane_0_rx_ser;
    logic             lane_1_rx_ser;
    logic [WIDTH-1:0] lane_0_rx_parallel;
    logic [WIDTH-1:0] lane_1_rx_parallel;
    logic             rx_valid;
    logic             descr_rst;
    logic             enable_descr;

    modport master (
        output enable_deser,
        output gen_speed,
        output lane_0_rx_ser,
        output lane_1_rx_ser,
        input  lane_0_rx_parallel,
        input  lane_1_rx_parallel,
        input  rx_valid,
        input  descr_rst,
        input  enable_descr
    );

    modport slave (
        input  enable_deser,
        input  gen_speed,
        input  lane_0_rx_ser,
        input  lane_1_rx_ser,
        output lane_0_rx_parallel,
        output lane_1_rx_parallel,
        output rx_valid,
        output descr_rst,
        output enable_descr
    );
endinterface : lanes_deserializer_if
`default_nettype wire

// File: rtl/lanes_deserializer_capture.sv
`default_nettype none
// ============================================================================
// Module      : lane_deser_capture
// Description : Per-lane capture shift store and held parallel output word.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_deser_capture
    import lanes_deserializer_pkg::*;
#(
    parameter int WIDTH = 132
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr,
    input  wire logic             i_restart,
    input  wire logic             i_done,
    input  wire logic [CNT_W-1:0] i_idx,
    input  wire logic             i_ser,
    output logic      [WIDTH-1:0] o_parallel
);

    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_par;
    logic [WIDTH-1:0] w_next;

    // A restart discards stale bits so the new word's upper bits read zero.
    always_comb begin
        w_next = i_restart ? '0 : r_cap;
        if (int'(i_idx) < WIDTH) begin
            w_next[i_idx] = i_ser;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap <= '0;
            r_par <= '0;
        end else if (!i_wr) begin
            r_cap <= '0;
        end else if (i_done) begin
            r_cap <= '0;
            r_par <= w_next;
        end else begin
            r_cap <= w_next;
        end
    end

    assign o_parallel = r_par;

endmodule : lane_deser_capture
`default_nettype wire

// File: rtl/lanes_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : lanes_deserializer
// Description : Two-lane LSB-first serial-to-parallel receiver, 8/66/132 bit.
// Revision    : 1.0 - initial release
// ============================================================================
module lanes_deserializer
    import lanes_deserializer_pkg::*;
#(
    parameter int WIDTH = 132
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lanes_deserializer_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len;
    logic [CNT_W-1:0] w_idx;
    logic             w_restart;
    logic             w_done;
    logic             r_valid;
    logic             r_descr_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.enable_deser)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!bus.enable_deser) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bits are captured on every enabled edge, including the IDLE->RUN edge,
    // so the first enabled cycle carries bit 0.  A length change while
    // running makes the current edge's bit the new word's bit 0.
    assign w_len     = word_len(bus.gen_speed);
    assign w_restart = (r_state == ST_RUN) && bus.enable_deser && (w_len != r_len);
    assign w_idx     = w_restart ? '0 : r_count;
    assign w_done    = bus.enable_deser && (w_idx == (w_len - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_len       <= LEN_GEN4;
            r_valid     <= 1'b0;
            r_descr_rst <= 1'b0;
        end else begin
            r_len       <= w_len;
            r_valid     <= w_done;
            r_descr_rst <= w_done;
            if (!bus.enable_deser || w_done) begin
                r_count <= '0;
            end else begin
                r_count <= w_idx + 1'b1;
            end
        end
    end

    lane_deser_capture #(.WIDTH(WIDTH)) u_lane0 (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (bus.enable_deser),
        .i_restart  (w_restart),
        .i_done     (w_done),
        .i_idx      (w_idx),
        .i_ser      (bus.lane_0_rx_ser),
        .o_parallel (bus.lane_0_rx_parallel)
    );

    lane_deser_capture #(.WIDTH(WIDTH)) u_lane1 (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (bus.enable_deser),
        .i_restart  (w_restart),
        .i_done     (w_done),
        .i_idx      (w_idx),
        .i_ser      (bus.lane_1_rx_ser),
        .o_parallel (bus.lane_1_rx_parallel)
    );

    assign bus.rx_valid     = r_valid;
    assign bus.descr_rst    = r_descr_rst;
    assign bus.enable_descr = (r_state == ST_RUN);

endmodule : lanes_deserializer
`default_nettype wire
